// File: rtl/aes_enc_iter.sv
//==============================================================================
// Module   : aes_enc_iter
// Brief    : Iterative AES-128/256 encryptor, one round per clock, on-the-fly key expansion.
// Revision : 1.0
//==============================================================================
`default_nettype none

module aes_enc_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_BITS-1:0] in_key,
  input  logic [127:0]        in_state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam logic [3:0] NR = (KEY_BITS == 128) ? 4'd10 : 4'd14;

  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [127:0]        r_s, r_out;
  logic [KEY_BITS-1:0] r_kw, w_kw_next;
  logic [3:0]          r_rnd;
  logic                w_accept, w_out_fire, w_last_round;

  logic [7:0]   w_sb [16];
  logic [7:0]   w_sr [16];
  logic [127:0] w_sr_flat, w_mc_flat, w_round_out, w_cipher;
  logic [127:0] w_kw_prev, w_newkey, w_rkey;
  logic [31:0]  w_kw_last, w_sw_in, w_temp;
  logic [3:0]   w_rcon_idx;
  logic         w_use_rot;

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    return c_SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] f_xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] f_rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // State byte i sits at row i%4, column i/4.
  always_comb begin
    for (int i = 0; i < 16; i++) w_sb[i] = f_sbox(r_s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
    for (int i = 0; i < 16; i++) w_sr_flat[127-8*i -: 8] = w_sr[i];
    for (int c = 0; c < 4; c++) begin
      w_mc_flat[127-32*c -: 8] = f_xt(w_sr[4*c]) ^ f_xt(w_sr[4*c+1]) ^ w_sr[4*c+1]
                                 ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc_flat[119-32*c -: 8] = w_sr[4*c] ^ f_xt(w_sr[4*c+1]) ^ f_xt(w_sr[4*c+2])
                                 ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc_flat[111-32*c -: 8] = w_sr[4*c] ^ w_sr[4*c+1] ^ f_xt(w_sr[4*c+2])
                                 ^ f_xt(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc_flat[103-32*c -: 8] = f_xt(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1]
                                 ^ w_sr[4*c+2] ^ f_xt(w_sr[4*c+3]);
    end
  end

  assign w_last_round = (r_rnd == NR);
  assign w_round_out  = w_last_round ? w_sr_flat : w_mc_flat;
  assign w_cipher     = w_round_out ^ w_rkey;

  // Oldest 4 words of the window feed the next 4 words; AES-256 odd rounds skip RotWord/rcon.
  assign w_kw_prev  = r_kw[KEY_BITS-1 -: 128];
  assign w_kw_last  = r_kw[31:0];
  assign w_use_rot  = (KEY_BITS == 128) || !r_rnd[0];
  assign w_rcon_idx = (KEY_BITS == 128) ? r_rnd : {1'b0, r_rnd[3:1]};
  assign w_sw_in    = w_use_rot ? {w_kw_last[23:0], w_kw_last[31:24]} : w_kw_last;
  assign w_temp     = {f_sbox(w_sw_in[31:24]), f_sbox(w_sw_in[23:16]),
                       f_sbox(w_sw_in[15:8]),  f_sbox(w_sw_in[7:0])}
                      ^ {(w_use_rot ? f_rcon(w_rcon_idx) : 8'h00), 24'h000000};

  assign w_newkey[127:96] = w_kw_prev[127:96] ^ w_temp;
  assign w_newkey[95:64]  = w_kw_prev[95:64] ^ w_kw_prev[127:96] ^ w_temp;
  assign w_newkey[63:32]  = w_kw_prev[63:32] ^ w_kw_prev[95:64] ^ w_kw_prev[127:96] ^ w_temp;
  assign w_newkey[31:0]   = w_kw_prev[31:0] ^ w_kw_prev[63:32] ^ w_kw_prev[95:64]
                            ^ w_kw_prev[127:96] ^ w_temp;

  generate
    if (KEY_BITS == 128) begin : g_ks128
      assign w_rkey    = w_newkey;
      assign w_kw_next = w_newkey;
    end else begin : g_ks256
      assign w_rkey    = (r_rnd == 4'd1) ? r_kw[127:0] : w_newkey;
      assign w_kw_next = (r_rnd == 4'd1) ? r_kw : {r_kw[127:0], w_newkey};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    w_out_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) w_state_next = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (w_last_round) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        w_out_fire = out_ready;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s   <= '0;
      r_kw  <= '0;
      r_rnd <= '0;
      r_out <= '0;
    end else if (w_accept) begin
      r_s   <= in_state ^ in_key[KEY_BITS-1 -: 128];
      r_kw  <= in_key;
      r_rnd <= 4'd1;
    end else if (r_state == S_ROUND) begin
      r_s  <= w_cipher;
      r_kw <= w_kw_next;
      if (w_last_round) r_out <= w_cipher;
      else              r_rnd <= r_rnd + 4'd1;
    end else if (w_out_fire) begin
      r_rnd <= 4'd0;
    end
  end

  assign out_data = r_out;

endmodule

`default_nettype wire

// File: tb/tb_aes_enc_iter.sv
//==============================================================================
// Module   : tb_aes_enc_iter
// Brief    : Scoreboard bench for aes_enc_iter, AES-128 and AES-256 instances.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_aes_enc_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_in_key, a_in_state, a_out_data;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [255:0] b_in_key;
  logic [127:0] b_in_state, b_out_data;

  aes_enc_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_key(a_in_key), .in_state(a_in_state), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  aes_enc_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_key(b_in_key), .in_state(b_in_state), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic a_prev_valid = 1'b0;
  logic b_prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: latency measured from acceptance edge to first out_valid, data on handshake.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_out_valid && !a_prev_valid) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 128'(a_out_valid), 128'd0);
      else                 check("a_latency", 128'(cyc - q_a[0].acc), 128'd10);
    end
    if (a_out_valid && a_out_ready && q_a.size() != 0) begin
      e = q_a.pop_front();
      check("a_data", a_out_data, e.data);
    end
    a_prev_valid = a_out_valid;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_out_valid && !b_prev_valid) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 128'(b_out_valid), 128'd0);
      else                 check("b_latency", 128'(cyc - q_b[0].acc), 128'd14);
    end
    if (b_out_valid && b_out_ready && q_b.size() != 0) begin
      e = q_b.pop_front();
      check("b_data", b_out_data, e.data);
    end
    b_prev_valid = b_out_valid;
  end

  task automatic send_a(input logic [127:0] key, input logic [127:0] pt,
                        input logic [127:0] exp, output int acc);
    int guard = 0;
    a_in_key   = key;
    a_in_state = pt;
    a_in_valid = 1'b1;
    while (!a_in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("a_in_ready_wait", 128'(a_in_ready), 128'd1);
    acc = cyc + 1;
    if (a_in_ready) q_a.push_back('{data: exp, acc: acc});
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [255:0] key, input logic [127:0] pt,
                        input logic [127:0] exp);
    int guard = 0;
    b_in_key   = key;
    b_in_state = pt;
    b_in_valid = 1'b1;
    while (!b_in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("b_in_ready_wait", 128'(b_in_ready), 128'd1);
    if (b_in_ready) q_b.push_back('{data: exp, acc: cyc + 1});
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int guard = 0;
    while (q_a.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("a_drain", 128'(q_a.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    int guard = 0;
    while (q_b.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("b_drain", 128'(q_b.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0, t1, guard;
    rst         = 1'b1;
    a_in_valid  = 1'b0; a_in_key = '0; a_in_state = '0; a_out_ready = 1'b1;
    b_in_valid  = 1'b0; b_in_key = '0; b_in_state = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: {in_ready, out_valid, busy}
    check("a_reset_flags", 128'({a_in_ready, a_out_valid, a_busy}), 128'b100);
    check("a_reset_data", a_out_data, 128'd0);
    check("b_reset_flags", 128'({b_in_ready, b_out_valid, b_busy}), 128'b100);
    check("b_reset_data", b_out_data, 128'd0);

    send_a(C1_KEY, C1_PT, C1_CT, t0);
    drain_a();

    send_a(C1_KEY, C1_PT, C1_CT, t0);
    send_a(B_KEY, B_PT, B_CT, t1);
    check("b2b_gap", 128'(t1 - t0), 128'd12);
    drain_a();

    // Backpressure with input noise while stalled in DONE
    a_out_ready = 1'b0;
    send_a(C1_KEY, C1_PT, C1_CT, t0);
    guard = 0;
    while (!a_out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("bp_valid_seen", 128'(a_out_valid), 128'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      a_in_valid = i[0];
      a_in_key   = {$urandom, $urandom, $urandom, $urandom};
      a_in_state = {$urandom, $urandom, $urandom, $urandom};
      check("bp_data_stable", a_out_data, C1_CT);
      check("bp_flags", 128'({a_in_ready, a_out_valid, a_busy}), 128'b011);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_flags", 128'({a_in_ready, a_out_valid, a_busy}), 128'b100);
    check("bp_queue_empty", 128'(q_a.size()), 128'd0);

    // Abort at round 5
    send_a(B_KEY, B_PT, B_CT, t0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    q_a.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_flags", 128'({a_in_ready, a_out_valid, a_busy}), 128'b100);
    check("abort_data", a_out_data, 128'd0);
    send_a(C1_KEY, C1_PT, C1_CT, t0);
    drain_a();

    send_b(C3_KEY, C1_PT, C3_CT);
    drain_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
